// File: rtl/store_queue_if.sv
// Signal bundle between the store queue and its LSU/ROB/memory neighbours.
// The queue side uses the slave modport; the environment uses master.
interface store_queue_if #(
    parameter int ID_W  = 7,
    parameter int COM_W = 2
) ();
    logic                       in_req;
    logic [ID_W-1:0]            in_id;
    logic                       in_cache;
    logic [31:0]                in_addr;
    logic [1:0]                 in_size;
    logic [31:0]                in_data;
    logic                       busy;
    logic [$clog2(COM_W+1)-1:0] com_num;
    logic                       rb;
    logic                       c_valid;
    logic                       c_ready;
    logic                       u_valid;
    logic                       u_ready;
    logic [31:0]                d_addr;
    logic [3:0]                 d_strobe;
    logic [31:0]                d_data;
    logic [ID_W-1:0]            d_id;
    logic [31:0]                ld_addr;
    logic [1:0]                 ld_size;
    logic                       ld_conflict;
    logic                       ld_fwd_valid;
    logic [31:0]                ld_fwd_data;
    logic                       empty;

    modport slave (
        input  in_req, in_id, in_cache, in_addr, in_size, in_data,
        input  com_num, rb, c_ready, u_ready, ld_addr, ld_size,
        output busy, c_valid, u_valid, d_addr, d_strobe, d_data, d_id,
        output ld_conflict, ld_fwd_valid, ld_fwd_data, empty
    );

    modport master (
        output in_req, in_id, in_cache, in_addr, in_size, in_data,
        output com_num, rb, c_ready, u_ready, ld_addr, ld_size,
        input  busy, c_valid, u_valid, d_addr, d_strobe, d_data, d_id,
        input  ld_conflict, ld_fwd_valid, ld_fwd_data, empty
    );
endinterface

// File: rtl/store_queue.sv
// In-order store buffer: holds speculative stores until commit, drops them on
// rollback, drains committed ones in order and forwards data to younger loads.
module store_queue #(
    parameter int DEPTH = 8,
    parameter int ID_W  = 7,
    parameter int COM_W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    store_queue_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [29:0]     wordAddr;
        logic [3:0]      strobe;
        logic [31:0]     data;
        logic [ID_W-1:0] id;
        logic            cache;
    } entry_t;

    entry_t           entries_q [DEPTH];
    ptr_t             head_q;
    ptr_t             comPtr_q;
    ptr_t             tail_q;
    ptr_t             head_d;
    ptr_t             comPtr_d;
    ptr_t             tail_d;
    ptr_t             count;
    ptr_t             uncommitted;
    ptr_t             comAdv;
    logic             full;
    logic             headVld;
    logic             headFire;
    logic             enqAccept;
    logic             cValid;
    logic             uValid;
    entry_t           headEnt;
    entry_t           newEnt;
    logic [3:0]       ldStrobe;
    logic             hit;
    logic [IDX_W-1:0] hitIdx;
    logic             hitCache;
    logic [3:0]       hitStrobe;
    logic [31:0]      hitData;
    logic             fwdValid;

    function automatic logic [3:0] laneStrobe(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd1:    laneStrobe = 4'b0001 << a;
            2'd2:    laneStrobe = 4'b0011 << {a[1], 1'b0};
            2'd3:    laneStrobe = 4'hF;
            default: laneStrobe = 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd1:    laneData = {4{d[7:0]}};
            2'd2:    laneData = {2{d[15:0]}};
            default: laneData = d;
        endcase
    endfunction

    assign count       = tail_q - head_q;
    assign uncommitted = tail_q - comPtr_q;
    assign full        = (count == ptr_t'(DEPTH));

    // Commit saturates at the number of uncommitted entries.
    always_comb begin
        comAdv = uncommitted;
        if (int'(bus.com_num) < int'(uncommitted)) begin
            comAdv = ptr_t'(bus.com_num);
        end
    end

    assign headEnt   = entries_q[head_q[IDX_W-1:0]];
    assign headVld   = (head_q != comPtr_q);
    assign cValid    = headVld && headEnt.cache;
    assign uValid    = headVld && !headEnt.cache;
    assign headFire  = (cValid && bus.c_ready) || (uValid && bus.u_ready);
    assign enqAccept = bus.in_req && !full && (bus.in_size != 2'd0) && !bus.rb;

    assign newEnt.wordAddr = bus.in_addr[31:2];
    assign newEnt.strobe   = laneStrobe(bus.in_size, bus.in_addr[1:0]);
    assign newEnt.data     = laneData(bus.in_size, bus.in_data);
    assign newEnt.id       = bus.in_id;
    assign newEnt.cache    = bus.in_cache;

    // Rollback pulls tail back to the commit point after this cycle's commit.
    assign head_d   = head_q + ptr_t'(headFire);
    assign comPtr_d = comPtr_q + comAdv;
    assign tail_d   = bus.rb ? comPtr_d : (tail_q + ptr_t'(enqAccept));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q   <= '0;
            comPtr_q <= '0;
            tail_q   <= '0;
        end else begin
            head_q   <= head_d;
            comPtr_q <= comPtr_d;
            tail_q   <= tail_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enqAccept) begin
            entries_q[tail_q[IDX_W-1:0]] <= newEnt;
        end
    end

    // Walk oldest to youngest so the last overlapping entry found is the youngest.
    always_comb begin
        ptr_t slot;
        slot     = '0;
        ldStrobe = laneStrobe(bus.ld_size, bus.ld_addr[1:0]);
        hit      = 1'b0;
        hitIdx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + ptr_t'(i);
            if ((ptr_t'(i) < count)
                && (entries_q[slot[IDX_W-1:0]].wordAddr == bus.ld_addr[31:2])
                && ((entries_q[slot[IDX_W-1:0]].strobe & ldStrobe) != 4'h0)) begin
                hit    = 1'b1;
                hitIdx = slot[IDX_W-1:0];
            end
        end
    end

    assign hitCache  = entries_q[hitIdx].cache;
    assign hitStrobe = entries_q[hitIdx].strobe;
    assign hitData   = entries_q[hitIdx].data;
    assign fwdValid  = hit && hitCache && ((hitStrobe & ldStrobe) == ldStrobe);

    assign bus.busy         = full;
    assign bus.empty        = (count == '0);
    assign bus.c_valid      = cValid;
    assign bus.u_valid      = uValid;
    assign bus.d_addr       = headVld ? {headEnt.wordAddr, 2'b00} : 32'h0;
    assign bus.d_strobe     = headVld ? headEnt.strobe : 4'h0;
    assign bus.d_data       = headVld ? headEnt.data : 32'h0;
    assign bus.d_id         = headVld ? headEnt.id : '0;
    assign bus.ld_conflict  = hit;
    assign bus.ld_fwd_valid = fwdValid;
    assign bus.ld_fwd_data  = fwdValid ? hitData : 32'h0;

    comNumInRange: assert property (@(posedge clk_i) disable iff (rst_i)
        int'(bus.com_num) <= int'(uncommitted));
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: lane/forwarding vector table plus sequences
// for fill, rollback, channel ordering, forwarding age, wrap and async reset.
module tb_store_queue;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    store_queue_if #(.ID_W(7), .COM_W(2)) sqIf ();

    store_queue #(.DEPTH(8), .ID_W(7), .COM_W(2)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (sqIf)
    );

    typedef struct {
        logic        cache;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic [31:0] ldAddr;
        logic [1:0]  ldSize;
        logic        expConflict;
        logic        expFwdValid;
        logic [31:0] expFwdData;
        logic [31:0] expDAddr;
        logic [3:0]  expStrobe;
        logic [31:0] expDData;
    } vec_t;

    vec_t        vecs [8];
    int          checks = 0;
    int          fails = 0;
    int          cn;
    int          unc;
    int          idCnt;
    int          refCom;
    logic        enqGo;
    logic        cr;
    logic        expBusy;
    logic        expValid;
    logic [31:0] wdata;
    logic [31:0] waddr;
    logic [31:0] refData [$];
    logic [6:0]  refId [$];
    logic [6:0]  expIds [3];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        sqIf.in_req   = 1'b0;
        sqIf.in_id    = '0;
        sqIf.in_cache = 1'b0;
        sqIf.in_addr  = '0;
        sqIf.in_size  = '0;
        sqIf.in_data  = '0;
        sqIf.com_num  = '0;
        sqIf.rb       = 1'b0;
        sqIf.c_ready  = 1'b0;
        sqIf.u_ready  = 1'b0;
        sqIf.ld_addr  = '0;
        sqIf.ld_size  = '0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // One enqueue attempt lasting a single clock.
    task automatic applyStimulus(input logic cache, input logic [31:0] addr, input logic [1:0] size,
                                 input logic [31:0] data, input logic [6:0] id);
        sqIf.in_req   = 1'b1;
        sqIf.in_cache = cache;
        sqIf.in_addr  = addr;
        sqIf.in_size  = size;
        sqIf.in_data  = data;
        sqIf.in_id    = id;
        tick();
        sqIf.in_req = 1'b0;
    endtask

    task automatic commitN(input int n);
        sqIf.com_num = 2'(n);
        tick();
        sqIf.com_num = '0;
    endtask

    task automatic checkLoad(input string name, input logic [31:0] addr, input logic [1:0] size,
                             input logic expC, input logic expV, input logic [31:0] expD);
        sqIf.ld_addr = addr;
        sqIf.ld_size = size;
        #1;
        checkOutput({name, " conflict"}, 32'(sqIf.ld_conflict), 32'(expC));
        checkOutput({name, " fwd_valid"}, 32'(sqIf.ld_fwd_valid), 32'(expV));
        checkOutput({name, " fwd_data"}, sqIf.ld_fwd_data, expD);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h103, 2'd1, 32'h0000_00AB, 32'h103, 2'd1, 1'b1, 1'b1, 32'hABAB_ABAB, 32'h100, 4'b1000, 32'hABAB_ABAB};
        vecs[1] = '{1'b1, 32'h202, 2'd2, 32'h0000_BEEF, 32'h200, 2'd3, 1'b1, 1'b0, 32'h0,         32'h200, 4'b1100, 32'hBEEF_BEEF};
        vecs[2] = '{1'b1, 32'h301, 2'd2, 32'h0000_1234, 32'h301, 2'd1, 1'b1, 1'b1, 32'h1234_1234, 32'h300, 4'b0011, 32'h1234_1234};
        vecs[3] = '{1'b0, 32'h403, 2'd3, 32'h1122_3344, 32'h400, 2'd1, 1'b1, 1'b0, 32'h0,         32'h400, 4'b1111, 32'h1122_3344};
        vecs[4] = '{1'b1, 32'h500, 2'd1, 32'h0000_005A, 32'h501, 2'd1, 1'b0, 1'b0, 32'h0,         32'h500, 4'b0001, 32'h5A5A_5A5A};
        vecs[5] = '{1'b1, 32'h602, 2'd1, 32'hFFFF_FF77, 32'h602, 2'd2, 1'b1, 1'b0, 32'h0,         32'h600, 4'b0100, 32'h7777_7777};
        vecs[6] = '{1'b1, 32'h700, 2'd3, 32'hCAFE_F00D, 32'h700, 2'd3, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h700, 4'b1111, 32'hCAFE_F00D};
        vecs[7] = '{1'b0, 32'h800, 2'd2, 32'h0000_9876, 32'h800, 2'd0, 1'b0, 1'b0, 32'h0,         32'h800, 4'b0011, 32'h9876_9876};

        rst = 1'b1;
        idleInputs();
        #1;
        checkOutput("reset busy", 32'(sqIf.busy), 32'd0);
        checkOutput("reset empty", 32'(sqIf.empty), 32'd1);
        checkOutput("reset c_valid", 32'(sqIf.c_valid), 32'd0);
        checkOutput("reset u_valid", 32'(sqIf.u_valid), 32'd0);
        checkOutput("reset ld_conflict", 32'(sqIf.ld_conflict), 32'd0);
        checkOutput("reset ld_fwd_valid", 32'(sqIf.ld_fwd_valid), 32'd0);
        checkOutput("reset d_addr", sqIf.d_addr, 32'd0);
        checkOutput("reset d_data", sqIf.d_data, 32'd0);
        tick();
        rst = 1'b0;
        #1;

        // Vector table: lane formatting, single-entry forwarding, drain channel.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].cache, vecs[i].addr, vecs[i].size, vecs[i].data, 7'(i));
            checkLoad($sformatf("vec%0d ld", i), vecs[i].ldAddr, vecs[i].ldSize,
                      vecs[i].expConflict, vecs[i].expFwdValid, vecs[i].expFwdData);
            commitN(1);
            checkOutput($sformatf("vec%0d c_valid", i), 32'(sqIf.c_valid), 32'(vecs[i].cache));
            checkOutput($sformatf("vec%0d u_valid", i), 32'(sqIf.u_valid), 32'(!vecs[i].cache));
            checkOutput($sformatf("vec%0d d_addr", i), sqIf.d_addr, vecs[i].expDAddr);
            checkOutput($sformatf("vec%0d d_strobe", i), 32'(sqIf.d_strobe), 32'(vecs[i].expStrobe));
            checkOutput($sformatf("vec%0d d_data", i), sqIf.d_data, vecs[i].expDData);
            checkOutput($sformatf("vec%0d d_id", i), 32'(sqIf.d_id), i);
            sqIf.c_ready = vecs[i].cache;
            sqIf.u_ready = !vecs[i].cache;
            tick();
            sqIf.c_ready = 1'b0;
            sqIf.u_ready = 1'b0;
            checkOutput($sformatf("vec%0d empty after drain", i), 32'(sqIf.empty), 32'd1);
        end
        sqIf.ld_size = '0;

        // Fill without commit; the ninth request must be dropped.
        resetDut();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'h1000 + 32'(4 * i), 2'd3, 32'hA000_0000 + 32'(i), 7'(i));
        checkOutput("fill busy after 7", 32'(sqIf.busy), 32'd0);
        applyStimulus(1'b1, 32'h101C, 2'd3, 32'hA000_0007, 7'd7);
        checkOutput("fill busy after 8", 32'(sqIf.busy), 32'd1);
        applyStimulus(1'b1, 32'h1020, 2'd3, 32'hDEAD_DEAD, 7'd99);
        checkOutput("fill busy after 9th", 32'(sqIf.busy), 32'd1);
        checkOutput("fill empty", 32'(sqIf.empty), 32'd0);
        checkOutput("fill c_valid", 32'(sqIf.c_valid), 32'd0);
        checkOutput("fill u_valid", 32'(sqIf.u_valid), 32'd0);
        for (int i = 0; i < 4; i++) commitN(2);
        sqIf.c_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("fill drain%0d c_valid", i), 32'(sqIf.c_valid), 32'd1);
            checkOutput($sformatf("fill drain%0d d_id", i), 32'(sqIf.d_id), i);
            checkOutput($sformatf("fill drain%0d d_data", i), sqIf.d_data, 32'hA000_0000 + 32'(i));
            tick();
            if (i == 0) checkOutput("fill busy after drain", 32'(sqIf.busy), 32'd0);
        end
        sqIf.c_ready = 1'b0;
        checkOutput("fill empty at end", 32'(sqIf.empty), 32'd1);

        // Commit two of three, then rollback with a same-cycle enqueue.
        resetDut();
        applyStimulus(1'b1, 32'h10, 2'd3, 32'h1, 7'd1);
        applyStimulus(1'b1, 32'h14, 2'd3, 32'h2, 7'd2);
        applyStimulus(1'b1, 32'h18, 2'd3, 32'h3, 7'd3);
        commitN(2);
        sqIf.rb = 1'b1;
        applyStimulus(1'b1, 32'h1C, 2'd3, 32'h9, 7'd9);
        sqIf.rb = 1'b0;
        checkOutput("rb c_valid", 32'(sqIf.c_valid), 32'd1);
        checkOutput("rb head id", 32'(sqIf.d_id), 32'd1);
        applyStimulus(1'b1, 32'h20, 2'd3, 32'hA, 7'd10);
        commitN(1);
        expIds = '{7'd1, 7'd2, 7'd10};
        sqIf.c_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rb drain%0d c_valid", i), 32'(sqIf.c_valid), 32'd1);
            checkOutput($sformatf("rb drain%0d d_id", i), 32'(sqIf.d_id), 32'(expIds[i]));
            tick();
        end
        sqIf.c_ready = 1'b0;
        checkOutput("rb empty at end", 32'(sqIf.empty), 32'd1);

        // An uncached head blocks a younger cached store.
        resetDut();
        applyStimulus(1'b0, 32'h40, 2'd3, 32'h4040_4040, 7'd20);
        applyStimulus(1'b1, 32'h44, 2'd3, 32'h4444_4444, 7'd21);
        commitN(2);
        sqIf.c_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("order wait%0d u_valid", i), 32'(sqIf.u_valid), 32'd1);
            checkOutput($sformatf("order wait%0d c_valid", i), 32'(sqIf.c_valid), 32'd0);
            checkOutput($sformatf("order wait%0d d_id", i), 32'(sqIf.d_id), 32'd20);
            tick();
        end
        sqIf.u_ready = 1'b1;
        tick();
        sqIf.u_ready = 1'b0;
        checkOutput("order next c_valid", 32'(sqIf.c_valid), 32'd1);
        checkOutput("order next u_valid", 32'(sqIf.u_valid), 32'd0);
        checkOutput("order next d_id", 32'(sqIf.d_id), 32'd21);
        tick();
        sqIf.c_ready = 1'b0;
        checkOutput("order empty", 32'(sqIf.empty), 32'd1);

        // Forwarding picks the youngest overlapping store.
        resetDut();
        applyStimulus(1'b1, 32'h200, 2'd3, 32'h1122_3344, 7'd30);
        applyStimulus(1'b1, 32'h202, 2'd2, 32'h0000_BEEF, 7'd31);
        checkLoad("age word 200", 32'h200, 2'd3, 1'b1, 1'b0, 32'h0);
        checkLoad("age half 202", 32'h202, 2'd2, 1'b1, 1'b1, 32'hBEEF_BEEF);
        checkLoad("age byte 201", 32'h201, 2'd1, 1'b1, 1'b1, 32'h1122_3344);
        checkLoad("age half 200", 32'h200, 2'd2, 1'b1, 1'b1, 32'h1122_3344);
        applyStimulus(1'b1, 32'h203, 2'd1, 32'h0000_0077, 7'd32);
        checkLoad("age half 202 partial", 32'h202, 2'd2, 1'b1, 1'b0, 32'h0);
        checkLoad("age byte 203", 32'h203, 2'd1, 1'b1, 1'b1, 32'h7777_7777);
        sqIf.ld_size = '0;

        // Wrap-around traffic against a reference queue.
        resetDut();
        refData.delete();
        refId.delete();
        refCom = 0;
        idCnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            enqGo = ($urandom_range(0, 3) != 0);
            cr    = 1'($urandom_range(0, 1));
            unc   = refData.size() - refCom;
            cn    = $urandom_range(0, 2);
            if (cn > unc) cn = unc;
            wdata = $urandom;
            waddr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            sqIf.in_req   = enqGo;
            sqIf.in_cache = 1'b1;
            sqIf.in_size  = 2'd3;
            sqIf.in_addr  = waddr;
            sqIf.in_data  = wdata;
            sqIf.in_id    = 7'(idCnt);
            sqIf.com_num  = 2'(cn);
            sqIf.c_ready  = cr;
            #1;
            expBusy  = (refData.size() == 8);
            expValid = (refCom > 0);
            checkOutput($sformatf("wrap%0d busy", cyc), 32'(sqIf.busy), 32'(expBusy));
            checkOutput($sformatf("wrap%0d c_valid", cyc), 32'(sqIf.c_valid), 32'(expValid));
            checkOutput($sformatf("wrap%0d u_valid", cyc), 32'(sqIf.u_valid), 32'd0);
            if (expValid) begin
                checkOutput($sformatf("wrap%0d d_data", cyc), sqIf.d_data, refData[0]);
                checkOutput($sformatf("wrap%0d d_id", cyc), 32'(sqIf.d_id), 32'(refId[0]));
            end
            if (expValid && cr) begin
                void'(refData.pop_front());
                void'(refId.pop_front());
                refCom--;
            end
            refCom += cn;
            if (enqGo && !expBusy) begin
                refData.push_back(wdata);
                refId.push_back(7'(idCnt));
                idCnt++;
            end
            tick();
        end
        idleInputs();

        // Leave a committed head presented, then reset asynchronously mid-cycle.
        expBusy = (refData.size() == 8);
        applyStimulus(1'b1, 32'h50, 2'd3, 32'h5050_5050, 7'(idCnt));
        if (!expBusy) begin
            refData.push_back(32'h5050_5050);
            refId.push_back(7'(idCnt));
        end
        while (refData.size() - refCom > 0) begin
            unc = refData.size() - refCom;
            cn  = (unc > 2) ? 2 : unc;
            commitN(cn);
            refCom += cn;
        end
        checkOutput("pre-reset c_valid", 32'(sqIf.c_valid), 32'd1);
        checkOutput("pre-reset d_id", 32'(sqIf.d_id), 32'(refId[0]));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset c_valid", 32'(sqIf.c_valid), 32'd0);
        checkOutput("async reset u_valid", 32'(sqIf.u_valid), 32'd0);
        checkOutput("async reset empty", 32'(sqIf.empty), 32'd1);
        checkOutput("async reset busy", 32'(sqIf.busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("after reset empty", 32'(sqIf.empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
